cpu_sequencer: RTL
==================

Name: cpu_sequencer

Overview:
- Fetch/decode/execute controller for the sample CPU.
- Sits directly upstream of the 64x8 memory: drives its address, store and write-data inputs, and consumes its registered read data.
- Holds PC, IR, accumulator and carry; executes 8-bit instructions of the form [7:6] opcode, [5:0] operand.
- Stores push the accumulator through the memory's internal descending store pointer.

Parameters:
- MAX_PUSH, 32, maximum stores allowed between resets (1..63); protects the program region from the descending store pointer.
- START_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high; clock clk
- run  in  1  start request; sampled only in IDLE
- mem_addr  out  6  memory address (combinational from state/pc/ir)
- mem_store  out  1  one-cycle store strobe to memory
- mem_wdata  out  8  store data (= acc)
- mem_rdata  in  8  memory read data; valid the cycle after mem_addr is presented
- acc_out  out  8  accumulator
- pc_out  out  6  program counter
- carry  out  1  carry from last ADD
- retire  out  1  one-cycle pulse in the final cycle of each instruction
- halted  out  1  sticky halt indicator
- fault  out  1  sticky store-overflow indicator

Behaviour:
- Reset: state=IDLE, pc=START_PC, ir=0, acc=0, carry=0, push_cnt=0, halted=0, fault=0, retire=0, mem_store=0, mem_addr=0, mem_wdata=0.
- Reset does not rewind the memory's store pointer; a bench must reload the memory image before repeating store tests.
- Opcodes:
  - 00 LOAD: acc=mem[op]; carry unchanged.
  - 01 ADD: {carry,acc}=acc+mem[op], 9-bit sum.
  - 10 STORE: push acc; operand ignored.
  - 11 with op!=63: JMP, pc=op.
  - 0xFF: HALT.
- States:
  - IDLE: mem_addr=pc; run=1 -> FETCH.
  - FETCH: mem_addr=pc -> DECODE.
  - DECODE: ir<=mem_rdata, pc<=pc+1 (6-bit wrap 63->0); then LOAD/ADD -> READ, STORE -> STORE, JMP: pc<=op, retire=1 -> FETCH, HALT: retire=1 -> HALT.
  - READ: mem_addr=ir[5:0] -> EXEC.
  - EXEC: update acc/carry from mem_rdata, retire=1 -> FETCH.
  - STORE: if push_cnt<MAX_PUSH then mem_store=1, mem_wdata=acc, push_cnt++, retire=1 -> FETCH; else mem_store=0, fault<=1 -> HALT (no retire).
  - HALT: halted=1; remains until reset; run ignored.
- Latency (cycles): LOAD/ADD 4, STORE 3, JMP 2, HALT 2 to enter HALT.
- mem_store is high for exactly one cycle per successful STORE, never in any other state.
- run held high re-triggers only from IDLE; after the first start it has no effect.
- Reset has priority over every state, including a STORE cycle: the strobe asserted in that same cycle is still seen by memory, but the controller counters clear.
- JMP to the current address loops forever and retires every 2 cycles; this is legal.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants OP_LOAD=2'b00, OP_ADD=2'b01, OP_STORE=2'b10, OP_JMP=2'b11, INSTR_HALT=8'hFF;
  - state enum {IDLE, FETCH, DECODE, READ, EXEC, STORE, HALT};
  - ADDR_W=6, DATA_W=8.
- Optional sub-module cpu_alu: combinational 8-bit LOAD/ADD with carry-out. FSM and registers stay in cpu_sequencer.

Test Plan:
- Reset held 2 cycles -> all outputs 0, pc_out=0, state IDLE; run=0 keeps mem_store=0 indefinitely.
- Program 0x0A,0x4B,0x80,0xFF with mem[10]=0x05, mem[11]=0x07, run pulse -> acc=0x0C, carry=0, one mem_store pulse with wdata 0x0C, memory[63]=0x0C, 4 retire pulses, halted=1 at 13 cycles after start, pc_out=4.
- Same program with mem[10]=0xF0, mem[11]=0x20 -> acc=0x10, carry=1, memory[63]=0x10.
- Program 0:0xC5, 5:0xFF -> pc 0->1->5->6, 2 retire pulses, halted=1, no store.
- MAX_PUSH=2, program 0x80,0x80,0x80 -> two store pulses (memory[63], memory[62]), third STORE gives fault=1, halted=1, no third pulse, 2 retire pulses.
- Reset asserted during READ of LOAD -> next cycle IDLE, acc=0, pc=0, mem_store=0; run after reset restarts from pc 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg -- shared widths, opcodes and controller states for the sample CPU.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;

    localparam logic [1:0]        OP_LOAD    = 2'b00;
    localparam logic [1:0]        OP_ADD     = 2'b01;
    localparam logic [1:0]        OP_STORE   = 2'b10;
    localparam logic [1:0]        OP_JMP     = 2'b11;
    localparam logic [DATA_W-1:0] INSTR_HALT = 8'hFF;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        READ   = 3'd3,
        EXEC   = 3'd4,
        STORE  = 3'd5,
        HALT   = 3'd6
    } state_t;

    function automatic logic [1:0] opcode_of(input logic [DATA_W-1:0] instr);
        return instr[DATA_W-1:DATA_W-2];
    endfunction

    function automatic logic [ADDR_W-1:0] operand_of(input logic [DATA_W-1:0] instr);
        return instr[ADDR_W-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_alu.sv
// ----------------------------------------------------------------------------
// cpu_alu -- combinational LOAD/ADD datapath with 9-bit carry-out.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cpu_alu
    import cpu_pkg::*;
(
    input  logic              is_add,
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] operand,
    input  logic              carry_in,
    output logic [DATA_W-1:0] result,
    output logic              carry_out
);

    logic [DATA_W:0] sum;

    assign sum = {1'b0, acc} + {1'b0, operand};

    // LOAD passes the operand through and leaves the carry untouched.
    always_comb begin
        result    = operand;
        carry_out = carry_in;
        if (is_add) begin
            result    = sum[DATA_W-1:0];
            carry_out = sum[DATA_W];
        end
    end

endmodule

`default_nettype wire

// File: rtl/cpu_sequencer.sv
// ----------------------------------------------------------------------------
// cpu_sequencer -- fetch/decode/execute controller driving the 64x8 memory.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int                MAX_PUSH = 32,
    parameter logic [ADDR_W-1:0] START_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_store,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] acc_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              carry,
    output logic              retire,
    output logic              halted,
    output logic              fault
);

    localparam logic [ADDR_W:0] PUSH_LIMIT = (ADDR_W+1)'(MAX_PUSH);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] ir_next;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_next;
    logic              carry_next;
    logic [ADDR_W:0]   push_cnt;
    logic [ADDR_W:0]   push_cnt_next;
    logic              fault_next;

    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;

    cpu_alu u_alu (
        .is_add    (opcode_of(ir) == OP_ADD),
        .acc       (acc),
        .operand   (mem_rdata),
        .carry_in  (carry),
        .result    (alu_result),
        .carry_out (alu_carry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pc       <= START_PC;
            ir       <= '0;
            acc      <= '0;
            carry    <= 1'b0;
            push_cnt <= '0;
            fault    <= 1'b0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            ir       <= ir_next;
            acc      <= acc_next;
            carry    <= carry_next;
            push_cnt <= push_cnt_next;
            fault    <= fault_next;
        end
    end

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        ir_next       = ir;
        acc_next      = acc;
        carry_next    = carry;
        push_cnt_next = push_cnt;
        fault_next    = fault;
        mem_addr      = pc;
        mem_store     = 1'b0;
        retire        = 1'b0;

        case (state)
            IDLE: begin
                if (run) begin
                    state_next = FETCH;
                end
            end

            FETCH: begin
                state_next = DECODE;
            end

            // Decode straight from the read data; ir only holds it for READ/EXEC.
            DECODE: begin
                ir_next = mem_rdata;
                pc_next = pc + ADDR_W'(1);
                if (mem_rdata == INSTR_HALT) begin
                    retire     = 1'b1;
                    state_next = HALT;
                end else begin
                    case (opcode_of(mem_rdata))
                        OP_LOAD, OP_ADD: state_next = READ;
                        OP_STORE:        state_next = STORE;
                        default: begin
                            pc_next    = operand_of(mem_rdata);
                            retire     = 1'b1;
                            state_next = FETCH;
                        end
                    endcase
                end
            end

            READ: begin
                mem_addr   = operand_of(ir);
                state_next = EXEC;
            end

            EXEC: begin
                acc_next   = alu_result;
                carry_next = alu_carry;
                retire     = 1'b1;
                state_next = FETCH;
            end

            // The push budget keeps the descending store pointer out of the program.
            STORE: begin
                if (push_cnt < PUSH_LIMIT) begin
                    mem_store     = 1'b1;
                    push_cnt_next = push_cnt + (ADDR_W+1)'(1);
                    retire        = 1'b1;
                    state_next    = FETCH;
                end else begin
                    fault_next = 1'b1;
                    state_next = HALT;
                end
            end

            HALT: begin
                state_next = HALT;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign mem_wdata = acc;
    assign acc_out   = acc;
    assign pc_out    = pc;
    assign halted    = (state == HALT);

endmodule

`default_nettype wire
